unison_readout_rx: RTL and testbench

//  - Digital receiving end of a unison's shared read_out_I/read_out_Q feedback bus; sits in the digital top beside the unison.
//  - Tracks the octave time-slot schedule, decodes the +/- feedback pulses and accumulates one signed count per octave per I/Q.
//  - At each frame boundary it snapshots all accumulators and streams them out over a valid/ready port.

---
 rtl/unison_rx_pkg.sv | 34 +++
 rtl/unison_slot_decode.sv | 31 +++
 rtl/unison_readout_rx.sv | 184 ++++++++++++++++++
 tb/tb_unison_readout_rx.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/unison_rx_pkg.sv
// Shared types for the unison read-out receiver.
// Octave index, FSM encoding, per-cycle sample bundle and fb decode.
package unison_rx_pkg;

  localparam int NUM_OCTAVES_DFLT = 8;

  typedef logic [2:0] oct_t;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } rx_state_e;

  typedef struct packed {
    logic       ud;
    logic [1:0] i;
    logic [1:0] q;
  } rx_sample_t;

  // 2'b11 is illegal on the bus and contributes nothing
  function automatic logic signed [1:0] fb_decode(
    input logic [1:0] fb
  );
    logic signed [1:0] d;
    d = 2'sd0;
    unique case (1'b1)
      fb == 2'b10: d = 2'sd1;
      fb == 2'b01: d = -2'sd1;
      default:     d = 2'sd0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/unison_slot_decode.sv
// Slot counter -> owning octave: slot is the number of trailing ones.
// Slots at or beyond NUM_OCTAVES are not owned by any octave.
module unison_slot_decode
  import unison_rx_pkg::*;
#(
  parameter int CNT_W       = 10,
  parameter int NUM_OCTAVES = NUM_OCTAVES_DFLT
) (
  input  logic [CNT_W-1:0] cnt,
  output logic             slot_valid,
  output oct_t             slot
);

  int unsigned ones;
  logic        hit_zero;

  always_comb begin
    ones     = CNT_W;
    hit_zero = 1'b0;
    for (int i = 0; i < CNT_W; i++) begin
      if (!hit_zero && !cnt[i]) begin
        hit_zero = 1'b1;
        ones     = i;
      end
    end
  end

  assign slot_valid = ones < NUM_OCTAVES;
  assign slot       = oct_t'(ones);

endmodule

// File: rtl/unison_readout_rx.sv
// Unison feedback-bus receiver: per-octave I/Q accumulation and frame stream-out.
// Define RX_SATURATE_EN for clamping accumulators; default wraps.
module unison_readout_rx
  import unison_rx_pkg::*;
#(
  parameter int NUM_OCTAVES = NUM_OCTAVES_DFLT,
  parameter int CNT_W       = 10,
  parameter int ACC_W       = 12
) (
  input  logic                    clk_master,
  input  logic                    rstb,
  input  logic                    ud_en,
  input  logic [1:0]              read_out_I,
  input  logic [1:0]              read_out_Q,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_data,
  output oct_t                    out_octave,
  output logic                    out_iq,
  output logic                    out_last,
  output logic                    overrun
);

  localparam int NW = 2 * NUM_OCTAVES;
  localparam int WW = $clog2(NW);
  localparam int OW = $clog2(NUM_OCTAVES);
  localparam logic [CNT_W-1:0] CNT_LAST = '1;

  rx_sample_t       smp;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] smp_cnt;
  logic             slot_valid;
  oct_t             slot;
  logic             boundary;

  // sample is tagged with the cnt it was driven under
  always_ff @(posedge clk_master or negedge rstb) begin
    if (!rstb) begin
      cnt     <= '0;
      smp_cnt <= '0;
      smp     <= '0;
    end else begin
      cnt     <= cnt + 1'b1;
      smp_cnt <= cnt;
      smp     <= rx_sample_t'{ud: ud_en, i: read_out_I, q: read_out_Q};
    end
  end

  unison_slot_decode #(
    .CNT_W      (CNT_W),
    .NUM_OCTAVES(NUM_OCTAVES)
  ) u_slot (
    .cnt       (smp_cnt),
    .slot_valid(slot_valid),
    .slot      (slot)
  );

  assign boundary = smp_cnt == CNT_LAST;

  logic signed [1:0]       delta [2];
  logic signed [ACC_W-1:0] acc     [NUM_OCTAVES][2];
  logic signed [ACC_W-1:0] acc_nxt [NUM_OCTAVES][2];
  logic signed [ACC_W-1:0] shadow  [NUM_OCTAVES][2];
  logic signed [1:0]       d;
  logic signed [ACC_W:0]   sum;
  rx_state_e               state;
  rx_state_e               state_nxt;

  assign delta[0] = fb_decode(smp.i);
  assign delta[1] = fb_decode(smp.q);

`ifdef RX_SATURATE_EN
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  logic sat     [NUM_OCTAVES][2];
  logic sat_nxt [NUM_OCTAVES][2];
`endif

  always_comb begin
    d   = 2'sd0;
    sum = '0;
    for (int o = 0; o < NUM_OCTAVES; o++) begin
      for (int c = 0; c < 2; c++) begin
        d = (smp.ud && slot_valid && slot == oct_t'(o)) ? delta[c] : 2'sd0;
        sum = $signed({acc[o][c][ACC_W-1], acc[o][c]})
            + $signed({{(ACC_W-1){d[1]}}, d});
`ifdef RX_SATURATE_EN
        // once clamped, an entry holds until the frame clears
        sat_nxt[o][c] = sat[o][c] | (sum[ACC_W] != sum[ACC_W-1]);
        if (sat[o][c])
          acc_nxt[o][c] = acc[o][c];
        else if (sum[ACC_W] != sum[ACC_W-1])
          acc_nxt[o][c] = sum[ACC_W] ? ACC_MIN : ACC_MAX;
        else
          acc_nxt[o][c] = sum[ACC_W-1:0];
`else
        acc_nxt[o][c] = sum[ACC_W-1:0];
`endif
      end
    end
  end

  always_ff @(posedge clk_master or negedge rstb) begin
    if (!rstb) begin
      for (int o = 0; o < NUM_OCTAVES; o++) begin
        for (int c = 0; c < 2; c++) begin
          acc[o][c]    <= '0;
          shadow[o][c] <= '0;
`ifdef RX_SATURATE_EN
          sat[o][c]    <= 1'b0;
`endif
        end
      end
    end else begin
      for (int o = 0; o < NUM_OCTAVES; o++) begin
        for (int c = 0; c < 2; c++) begin
          acc[o][c] <= boundary ? '0 : acc_nxt[o][c];
          if (boundary && state == IDLE)
            shadow[o][c] <= acc_nxt[o][c];
`ifdef RX_SATURATE_EN
          sat[o][c] <= boundary ? 1'b0 : sat_nxt[o][c];
`endif
        end
      end
    end
  end

  logic [WW-1:0] w;
  logic [WW-1:0] w_nxt;
  logic [OW-1:0] w_oct;

  assign w_oct = w[WW-1:1];

  always_ff @(posedge clk_master or negedge rstb) begin
    if (!rstb) begin
      state   <= IDLE;
      w       <= '0;
      overrun <= 1'b0;
    end else begin
      state   <= state_nxt;
      w       <= w_nxt;
      overrun <= overrun | (boundary && state == STREAM);
    end
  end

  always_comb begin
    state_nxt = state;
    w_nxt     = w;
    unique case (state)
      IDLE: begin
        if (boundary) begin
          state_nxt = STREAM;
          w_nxt     = '0;
        end
      end
      STREAM: begin
        if (out_ready) begin
          w_nxt = w + 1'b1;
          if (w == WW'(NW - 1)) begin
            state_nxt = IDLE;
            w_nxt     = '0;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    out_valid  = 1'b0;
    out_data   = '0;
    out_octave = '0;
    out_iq     = 1'b0;
    out_last   = 1'b0;
    if (state == STREAM) begin
      out_valid  = 1'b1;
      out_data   = shadow[w_oct][w[0]];
      out_octave = oct_t'(w_oct);
      out_iq     = w[0];
      out_last   = w == WW'(NW - 1);
    end
  end

endmodule

// File: tb/tb_unison_readout_rx.sv
// Self-checking bench for unison_readout_rx: directed frame table,
// multi-cycle corner sequences and randomized traffic against a frame model.
module tb_unison_readout_rx;

  localparam int CNT_W = 10;
  localparam int NFR   = 1 << CNT_W;
  localparam int NO    = 8;

  logic              clk = 1'b0;
  logic              rstb = 1'b0;
  logic              ud_en = 1'b0;
  logic              out_ready = 1'b0;
  logic [1:0]        ri = 2'b00;
  logic [1:0]        rq = 2'b00;
  logic              out_valid;
  logic signed [11:0] out_data;
  logic [2:0]        out_octave;
  logic              out_iq;
  logic              out_last;
  logic              overrun;
  logic              v8;
  logic signed [7:0] d8;
  logic [2:0]        o8;
  logic              iq8;
  logic              l8;
  logic              ovr8;

  always #5 clk = ~clk;

  unison_readout_rx #(.NUM_OCTAVES(NO), .CNT_W(CNT_W), .ACC_W(12)) dut (
    .clk_master(clk), .rstb(rstb), .ud_en(ud_en),
    .read_out_I(ri), .read_out_Q(rq),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_octave(out_octave), .out_iq(out_iq), .out_last(out_last),
    .overrun(overrun)
  );

  unison_readout_rx #(.NUM_OCTAVES(NO), .CNT_W(CNT_W), .ACC_W(8)) dut8 (
    .clk_master(clk), .rstb(rstb), .ud_en(ud_en),
    .read_out_I(ri), .read_out_Q(rq),
    .out_valid(v8), .out_ready(out_ready), .out_data(d8),
    .out_octave(o8), .out_iq(iq8), .out_last(l8),
    .overrun(ovr8)
  );

  typedef struct {
    int data;
    int oct;
    int iq;
    bit last;
  } word_t;

  typedef struct {
    string name;
    int    pat;
    int    exp_i[NO];
  } vec_t;

  word_t exp_q[$];
  int    acc_m[NO][2];
  int    saved[NO][2];
  int    rx_w[NO][2];
  int    rx8_0;
  int    cnt_m, prev_c, frame_no, n37, words_rx;
  bit    busy, ovr_m;
  int    checks = 0;
  int    failures = 0;
  vec_t  tbl[3];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic int tones(input int c);
    int k = 0;
    while ((c % 2) == 1 && k < CNT_W) begin
      c = c / 2;
      k++;
    end
    return k;
  endfunction

  function automatic int dec(input logic [1:0] f);
    if (f == 2'b10) return 1;
    if (f == 2'b01) return -1;
    return 0;
  endfunction

  task automatic model_reset();
    cnt_m = 0; prev_c = -1; frame_no = 0; n37 = 0; words_rx = 0;
    busy = 0; ovr_m = 0; rx8_0 = -999;
    exp_q.delete();
    for (int o = 0; o < NO; o++)
      for (int c = 0; c < 2; c++) begin
        acc_m[o][c] = 0;
        rx_w[o][c] = -999;
      end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstb = 1'b0; ud_en = 1'b0; ri = 2'b00; rq = 2'b00; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rstb = 1'b1;
    model_reset();
  endtask

  // one cycle: drive at a negedge, observe, update model, wait next negedge
  task automatic step(input int pat, input int rmode, input bit fin);
    int         c, s;
    logic [1:0] i_v, q_v;
    bit         u, fire, bb;
    word_t      w;
    c = cnt_m; s = tones(c);
    u = 1'b1; i_v = 2'b00; q_v = 2'b00;
    case (pat)
      1: if (frame_no == 0) i_v = 2'b10;
      2: if (frame_no == 0 && s == 3 && n37 < 37) begin
           i_v = 2'b01; n37++;
         end
      3: if (frame_no == 0) i_v = 2'b11;
      4: if (frame_no == 0 && s == 0) i_v = 2'b10;
      5: begin
           u = $urandom_range(0, 3) != 0;
           i_v = 2'($urandom);
           q_v = 2'($urandom);
         end
      default: ;
    endcase
    ud_en = u; ri = i_v; rq = q_v;
    out_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? 1'b0
              : ($urandom_range(0, 2) != 0);
    #1;
    if (fin) begin
      chk("valid_vs_model", int'(out_valid), int'(busy));
      chk("overrun_vs_model", int'(overrun), int'(ovr_m));
    end
    bb = busy;
    fire = out_valid && out_ready;
    if (fire) begin
      if (exp_q.size() == 0) chk("unexpected_word", 1, 0);
      else begin
        w = exp_q.pop_front();
        chk("word_data", int'(out_data), w.data);
        chk("word_tag", int'({out_octave, out_iq, out_last}),
            int'({3'(w.oct), w.iq[0], w.last}));
        rx_w[out_octave][out_iq] = int'(out_data);
        if (out_octave == 3'd0 && !out_iq) rx8_0 = int'(d8);
        words_rx++;
        if (w.last) busy = 0;
      end
    end
    if (prev_c == NFR - 1) begin
      if (bb) ovr_m = 1;
      else begin
        for (int o = 0; o < NO; o++)
          for (int q = 0; q < 2; q++)
            exp_q.push_back('{saved[o][q], o, q, (o == NO - 1 && q == 1)});
        busy = 1;
      end
    end
    if (u && s < NO) begin
      acc_m[s][0] += dec(i_v);
      acc_m[s][1] += dec(q_v);
    end
    if (c == NFR - 1) begin
      saved = acc_m;
      for (int o = 0; o < NO; o++) begin
        acc_m[o][0] = 0;
        acc_m[o][1] = 0;
      end
      frame_no++;
    end
    prev_c = c;
    cnt_m = (c + 1) % NFR;
    @(negedge clk);
  endtask

  task automatic run(input int n, input int pat, input int rmode);
    for (int i = 0; i < n; i++) step(pat, rmode, i == n - 1);
  endtask

  initial begin
    tbl[0].name = "all_plus";  tbl[0].pat = 1;
    tbl[0].exp_i = '{512, 256, 128, 64, 32, 16, 8, 4};
    tbl[1].name = "oct3_m37";  tbl[1].pat = 2;
    tbl[1].exp_i = '{0, 0, 0, -37, 0, 0, 0, 0};
    tbl[2].name = "illegal11"; tbl[2].pat = 3;
    tbl[2].exp_i = '{0, 0, 0, 0, 0, 0, 0, 0};

    #12;
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_data", int'(out_data), 0);
    chk("rst_last", int'(out_last), 0);
    chk("rst_overrun", int'(overrun), 0);

    for (int t = 0; t < 3; t++) begin
      do_reset();
      run(NFR + 40, tbl[t].pat, 0);
      for (int o = 0; o < NO; o++) begin
        chk({tbl[t].name, "_I"}, rx_w[o][0], tbl[t].exp_i[o]);
        chk({tbl[t].name, "_Q"}, rx_w[o][1], 0);
      end
      chk({tbl[t].name, "_words"}, words_rx, 16);
    end

    do_reset();
    run(NFR + 40, 4, 0);
    chk("slot0_acc12", rx_w[0][0], 512);
`ifdef RX_SATURATE_EN
    chk("slot0_acc8_sat", rx8_0, 127);
`else
    chk("slot0_acc8_wrap", rx8_0, 0);
`endif

    do_reset();
    run(2 * NFR + 40, 1, 1);
    chk("stall_overrun", int'(overrun), 1);
    chk("stall_valid", int'(out_valid), 1);
    chk("stall_word0", int'(out_data), 512);
    run(60, 0, 0);
    chk("stall_words", words_rx, 16);
    chk("stall_oct0", rx_w[0][0], 512);
    chk("stall_oct7", rx_w[7][0], 4);

    do_reset();
    for (int i = 0; i < NFR + 40 && words_rx < 5; i++) step(1, 0, 1'b0);
    chk("midrst_reached_w5", words_rx, 5);
    chk("midrst_w5_tag", int'({out_octave, out_iq}), int'({3'd2, 1'b1}));
    #2 rstb = 1'b0;
    #1;
    chk("midrst_valid", int'(out_valid), 0);
    chk("midrst_data", int'(out_data), 0);
    do_reset();
    run(NFR + 40, 1, 0);
    chk("midrst_words", words_rx, 16);
    chk("midrst_oct0", rx_w[0][0], 512);
    chk("midrst_oct7", rx_w[7][0], 4);

    do_reset();
    run(3 * NFR + 100, 5, 2);
    chk("rand_words", words_rx, 48);
    chk("rand_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
